// File: rtl/motor_ramp_ctrl.sv
// -----------------------------------------------------------------------------
// motor_ramp_ctrl
//
// Drives one of N_CH motor channels at a time. Outputs an 8-bit speed pattern
// selected by a ramped level (0..3), and a serial drive bit for the connected
// channel made by rotating that pattern through an 8-step phase counter.
// The level moves by at most one step per RAMP_DIV clock cycles (soft
// start/stop). A channel change is break-before-make: the active channel
// drains to level 0 before the new channel is connected.
//
// Ports
//   clk      in   1      system clock, rising edge
//   rst_n    in   1      asynchronous active-low reset
//   sel      in   SEL_W  requested channel (values >= N_CH are ignored)
//   speed    in   4      requested speed code
//   cur_ch   out  SEL_W  channel currently connected
//   cur_lvl  out  2      current ramped level, 0..3
//   pat_out  out  8      pattern for cur_lvl: 0 / PAT1 / PAT2 / PAT3
//   drive    out  N_CH   serial drive; only bit cur_ch can be non-zero
//   busy     out  1      ramp or drain in progress
//
// FSM states
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   ST_RUN    | channel connected; level tracks the speed target per tick
//   ST_DRAIN  | switch pending; level steps down per tick, then reconnects
// -----------------------------------------------------------------------------
module motor_ramp_ctrl #(
    parameter int          N_CH     = 4,
    parameter int          SEL_W    = 2,
    parameter int          RAMP_DIV = 16,
    parameter logic [7:0]  PAT1     = 8'h0F,
    parameter logic [7:0]  PAT2     = 8'h33,
    parameter logic [7:0]  PAT3     = 8'hC3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] sel,
    input  logic [3:0]       speed,
    output logic [SEL_W-1:0] cur_ch,
    output logic [1:0]       cur_lvl,
    output logic [7:0]       pat_out,
    output logic [N_CH-1:0]  drive,
    output logic             busy
);

    localparam int DIV_W = $clog2(RAMP_DIV);

    // N_CH always fits in SEL_W+1 bits because 2**SEL_W >= N_CH.
    localparam logic [SEL_W:0] N_CH_L = (SEL_W + 1)'(N_CH);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [DIV_W-1:0] div;
    logic             tick;
    logic [2:0]       phase;
    logic             sel_valid;
    logic             switch_req;
    logic [1:0]       tgt;
    logic [1:0]       lvl_nxt;
    logic [SEL_W-1:0] ch_nxt;
    logic             busy_nxt;

    // -------------------------------------------------------------------------
    // Ramp tick divider and pattern phase, both free-running from reset
    // -------------------------------------------------------------------------
    assign tick = (div == DIV_W'(RAMP_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div   <= '0;
            phase <= '0;
        end else begin
            div   <= tick ? '0 : div + DIV_W'(1);
            phase <= phase + 3'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    assign sel_valid  = ({1'b0, sel} < N_CH_L);
    assign switch_req = sel_valid && (sel != cur_ch);

    // An out-of-range selection parks the current channel at level 0.
    always_comb begin
        tgt = 2'd0;
        if (sel_valid) begin
            if (speed == 4'd0) begin
                tgt = 2'd0;
            end else if (speed <= 4'd2) begin
                tgt = 2'd1;
            end else if (speed <= 4'd7) begin
                tgt = 2'd2;
            end else begin
                tgt = 2'd3;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ch_nxt    = cur_ch;
        lvl_nxt   = cur_lvl;
        case (state)
            ST_RUN: begin
                // A switch request wins over a ramp step in the same cycle.
                if (switch_req) begin
                    if (cur_lvl == 2'd0) begin
                        ch_nxt = sel;
                    end else begin
                        state_nxt = ST_DRAIN;
                    end
                end else if (tick) begin
                    if (cur_lvl < tgt) begin
                        lvl_nxt = cur_lvl + 2'd1;
                    end else if (cur_lvl > tgt) begin
                        lvl_nxt = cur_lvl - 2'd1;
                    end
                end
            end
            ST_DRAIN: begin
                // Only the sel value present on the final drain edge matters.
                if (tick) begin
                    if (cur_lvl <= 2'd1) begin
                        lvl_nxt   = 2'd0;
                        state_nxt = ST_RUN;
                        if (sel_valid) begin
                            ch_nxt = sel;
                        end
                    end else begin
                        lvl_nxt = cur_lvl - 2'd1;
                    end
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase

        // busy describes the post-edge state against the target seen at the edge.
        busy_nxt = (state_nxt == ST_DRAIN) || (lvl_nxt != tgt);
    end

    // -------------------------------------------------------------------------
    // FSM registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_RUN;
            cur_ch  <= '0;
            cur_lvl <= 2'd0;
            busy    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cur_ch  <= ch_nxt;
            cur_lvl <= lvl_nxt;
            busy    <= busy_nxt;
        end
    end

    // -------------------------------------------------------------------------
    // Output decode, from registers only
    // -------------------------------------------------------------------------
    always_comb begin
        case (cur_lvl)
            2'd1:    pat_out = PAT1;
            2'd2:    pat_out = PAT2;
            2'd3:    pat_out = PAT3;
            default: pat_out = 8'h00;
        endcase
    end

    always_comb begin
        drive = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (cur_ch == SEL_W'(i)) begin
                drive[i] = pat_out[phase];
            end
        end
    end

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
module tb_motor_ramp_ctrl;

    localparam int RD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] sel0, sel1;
    logic [3:0] speed0, speed1;

    logic [1:0] cur_ch0, cur_lvl0, cur_ch1, cur_lvl1;
    logic [7:0] pat0, pat1;
    logic [3:0] drive0;
    logic [2:0] drive1;
    logic       busy0, busy1;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state, index 0 = N_CH 4 build, 1 = N_CH 3 build
    int m_ch[2];
    int m_lvl[2];
    bit m_drain[2];
    bit m_busy[2];
    int m_n;
    int nch[2] = '{4, 3};

    always #5 clk = ~clk;

    motor_ramp_ctrl #(.N_CH(4), .SEL_W(2), .RAMP_DIV(RD)) dut0 (
        .clk(clk), .rst_n(rst_n), .sel(sel0), .speed(speed0),
        .cur_ch(cur_ch0), .cur_lvl(cur_lvl0), .pat_out(pat0),
        .drive(drive0), .busy(busy0)
    );

    motor_ramp_ctrl #(.N_CH(3), .SEL_W(2), .RAMP_DIV(RD)) dut1 (
        .clk(clk), .rst_n(rst_n), .sel(sel1), .speed(speed1),
        .cur_ch(cur_ch1), .cur_lvl(cur_lvl1), .pat_out(pat1),
        .drive(drive1), .busy(busy1)
    );

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int tgt_of(input int sp, input int s, input int n);
        if (s >= n)  return 0;
        if (sp == 0) return 0;
        if (sp <= 2) return 1;
        if (sp <= 7) return 2;
        return 3;
    endfunction

    function automatic logic [7:0] pat_of(input int lvl);
        case (lvl)
            1:       return 8'h0F;
            2:       return 8'h33;
            3:       return 8'hC3;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [31:0] drive_exp(input int k);
        logic [7:0] p;
        p = pat_of(m_lvl[k]);
        return p[m_n % 8] ? (32'd1 << m_ch[k]) : 32'd0;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ch[k] = 0; m_lvl[k] = 0; m_drain[k] = 0; m_busy[k] = 0;
        end
        m_n = 0;
    endtask

    // One clock edge of the behavioural model, applied to both builds.
    task automatic model_edge();
        bit tick;
        tick = ((m_n % RD) == RD - 1);
        for (int k = 0; k < 2; k++) begin
            int s, sp, tgt;
            bit valid;
            s     = (k == 0) ? int'(sel0)   : int'(sel1);
            sp    = (k == 0) ? int'(speed0) : int'(speed1);
            valid = (s < nch[k]);
            tgt   = tgt_of(sp, s, nch[k]);
            if (!m_drain[k]) begin
                if (valid && s != m_ch[k]) begin
                    if (m_lvl[k] == 0) m_ch[k] = s;
                    else               m_drain[k] = 1;
                end else if (tick) begin
                    if (m_lvl[k] < tgt)      m_lvl[k]++;
                    else if (m_lvl[k] > tgt) m_lvl[k]--;
                end
            end else if (tick) begin
                m_lvl[k]--;
                if (m_lvl[k] == 0) begin
                    m_drain[k] = 0;
                    if (valid) m_ch[k] = s;
                end
            end
            m_busy[k] = m_drain[k] || (m_lvl[k] != tgt);
        end
        m_n++;
    endtask

    task automatic check_outputs();
        check_val("ch0",    32'(cur_ch0),  32'(m_ch[0]));
        check_val("lvl0",   32'(cur_lvl0), 32'(m_lvl[0]));
        check_val("pat0",   32'(pat0),     32'(pat_of(m_lvl[0])));
        check_val("drive0", 32'(drive0),   drive_exp(0));
        check_val("busy0",  32'(busy0),    32'(m_busy[0]));
        check_val("ch1",    32'(cur_ch1),  32'(m_ch[1]));
        check_val("lvl1",   32'(cur_lvl1), 32'(m_lvl[1]));
        check_val("pat1",   32'(pat1),     32'(pat_of(m_lvl[1])));
        check_val("drive1", 32'(drive1),   drive_exp(1));
        check_val("busy1",  32'(busy1),    32'(m_busy[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_lvl0(input int target, input int limit);
        int i = 0;
        while (m_lvl[0] != target && i < limit) begin
            step();
            i++;
        end
        check_val("wait_lvl0", 32'(cur_lvl0), 32'(target));
    endtask

    // Asynchronous reset taken between edges; outputs must clear at once.
    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_lvl0",   32'(cur_lvl0), 32'd0);
        check_val("arst_ch0",    32'(cur_ch0),  32'd0);
        check_val("arst_pat0",   32'(pat0),     32'd0);
        check_val("arst_drive0", 32'(drive0),   32'd0);
        check_val("arst_busy0",  32'(busy0),    32'd0);
        check_val("arst_lvl1",   32'(cur_lvl1), 32'd0);
        check_val("arst_drive1", 32'(drive1),   32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs();
    endtask

    initial begin
        sel0 = 2'd0; speed0 = 4'd9;
        sel1 = 2'd1; speed1 = 4'd5;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_val("rst_lvl0",  32'(cur_lvl0), 32'd0);
        check_val("rst_busy0", 32'(busy0),    32'd0);
        rst_n = 1'b1;
        check_outputs();

        // ramp ch0 to level 3, ch1 of the 3-channel build to level 2
        run(16);
        check_val("up_lvl3",  32'(cur_lvl0), 32'd3);
        check_val("up_pat",   32'(pat0),     32'hC3);
        check_val("up_busy",  32'(busy0),    32'd0);
        check_val("n3_lvl2",  32'(cur_lvl1), 32'd2);

        // break-before-make 0 -> 2; invalid sel on the 3-channel build
        sel0 = 2'd2; speed0 = 4'd1;
        sel1 = 2'd3;
        run(2);
        check_val("drain_busy", 32'(busy0), 32'd1);
        run(30);
        check_val("sw_ch2",    32'(cur_ch0),  32'd2);
        check_val("sw_lvl",    32'(cur_lvl0), 32'd1);
        check_val("inv_ch1",   32'(cur_ch1),  32'd1);
        check_val("inv_lvl0",  32'(cur_lvl1), 32'd0);
        sel1 = 2'd1;
        run(12);
        check_val("resume_lvl", 32'(cur_lvl1), 32'd2);

        // immediate switch at level 0
        speed0 = 4'd0;
        run(8);
        sel0 = 2'd1;
        step();
        check_val("imm_ch1",  32'(cur_ch0), 32'd1);
        check_val("imm_busy", 32'(busy0),   32'd0);

        // speed reduced mid-ramp
        speed0 = 4'd15;
        wait_lvl0(2, 20);
        speed0 = 4'd1;
        run(10);
        check_val("rev_lvl1", 32'(cur_lvl0), 32'd1);
        check_val("rev_pat",  32'(pat0),     32'h0F);
        check_val("rev_busy", 32'(busy0),    32'd0);

        // reset in the middle of a drain
        speed0 = 4'd15;
        run(16);
        sel0 = 2'd3;
        wait_lvl0(2, 20);
        sel0 = 2'd0;
        async_reset();
        run(16);
        check_val("post_rst_lvl", 32'(cur_lvl0), 32'd3);

        // randomized traffic
        for (int c = 0; c < 2000; c++) begin
            if ($urandom_range(0, 11) == 0) sel0   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7)  == 0) speed0 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) sel1   = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7)  == 0) speed1 = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 499) == 0) async_reset();
            else step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
